// File: rtl/blink_pkg.sv
// Shared types and constants for the LED blink emitter.
package blink_pkg;

   // Blink sequencer states: waiting, LED lit, LED dark gap.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      OFF  = 2'd2
   } state_t;

   // 0.5 s at a 50 MHz system clock.
   localparam int BLINK_ON_DEFAULT  = 25_000_000;
   localparam int BLINK_OFF_DEFAULT = 25_000_000;

   // Timer must hold max(on, off) - 1; never narrower than one bit.
   function automatic int timer_width(input int a, input int b);
      int m;
      int w;
      m = (a > b) ? a : b;
      w = $clog2(m);
      return (w < 1) ? 1 : w;
   endfunction

endpackage

// File: rtl/led_blink_emitter_tick_timer.sv
// Loadable down-counter with a registered zero flag.
// The zero flag always tracks (counter == 0) in the same cycle, so the
// owner can act on the last cycle of a period without a comparator.
module tick_timer #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         load,
   input  logic [W-1:0] value,
   output logic         zero
);

   logic [W-1:0] cnt;

   // Load takes priority; otherwise count down and stop at zero.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt  <= '0;
         zero <= 1'b1;
      end else if (load) begin
         cnt  <= value;
         zero <= (value == '0);
      end else if (cnt != '0) begin
         cnt  <= cnt - W'(1);
         zero <= (cnt == W'(1));
      end else begin
         zero <= 1'b1;
      end
   end

endmodule

// File: rtl/led_blink_emitter.sv
// Blinks one LED a latched number of times with programmable on/off
// durations, then pulses done. Every sequence ends with a dark gap so
// consecutive requests remain visually distinct.
//
// Handshake: start is a request sampled on each rising clk edge and is
// accepted only while busy = 0; count is captured on that same edge.
// done is a one-cycle completion pulse; a new start is accepted on the
// edge that ends the done cycle. Nothing is sampled while busy = 1.
module led_blink_emitter
   import blink_pkg::*;
#(
   parameter int ON_CYCLES  = BLINK_ON_DEFAULT,
   parameter int OFF_CYCLES = BLINK_OFF_DEFAULT
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       start,
   input  logic [3:0] count,
   output logic       led,
   output logic       busy,
   output logic       done,
   output logic [3:0] remaining,
   output state_t     fsm_state
);

   localparam int TIMER_W = timer_width(ON_CYCLES, OFF_CYCLES);
   localparam logic [TIMER_W-1:0] ON_LOAD  = TIMER_W'(ON_CYCLES - 1);
   localparam logic [TIMER_W-1:0] OFF_LOAD = TIMER_W'(OFF_CYCLES - 1);

   state_t               state;
   logic                 timer_load;
   logic [TIMER_W-1:0]   timer_value;
   logic                 timer_zero;

   assign fsm_state = state;

   // Timer reload decode: one load on every transition into ON or OFF.
   always_comb begin
      timer_load  = 1'b0;
      timer_value = '0;
      case (state)
         IDLE: begin
            if (start && (count != 4'd0)) begin
               timer_load  = 1'b1;
               timer_value = ON_LOAD;
            end
         end
         ON: begin
            if (timer_zero) begin
               timer_load  = 1'b1;
               timer_value = OFF_LOAD;
            end
         end
         OFF: begin
            if (timer_zero && (remaining != 4'd0)) begin
               timer_load  = 1'b1;
               timer_value = ON_LOAD;
            end
         end
         default: begin
            timer_load  = 1'b0;
            timer_value = '0;
         end
      endcase
   end

   tick_timer #(
      .W (TIMER_W)
   ) u_timer (
      .clk   (clk),
      .reset (reset),
      .load  (timer_load),
      .value (timer_value),
      .zero  (timer_zero)
   );

   // Sequencer with registered led/busy/done/remaining.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state     <= IDLE;
         led       <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         remaining <= 4'd0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  if (count != 4'd0) begin
                     state     <= ON;
                     led       <= 1'b1;
                     busy      <= 1'b1;
                     remaining <= count;
                  end else begin
                     // Zero-length request completes immediately.
                     done <= 1'b1;
                  end
               end
            end
            ON: begin
               if (timer_zero) begin
                  // remaining is at least 1 here, so this cannot wrap.
                  state     <= OFF;
                  led       <= 1'b0;
                  remaining <= remaining - 4'd1;
               end
            end
            OFF: begin
               if (timer_zero) begin
                  if (remaining != 4'd0) begin
                     state <= ON;
                     led   <= 1'b1;
                  end else begin
                     state <= IDLE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                  end
               end
            end
            default: begin
               state     <= IDLE;
               led       <= 1'b0;
               busy      <= 1'b0;
               remaining <= 4'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_led_blink_emitter.sv
// Directed bench for led_blink_emitter with ON_CYCLES=3, OFF_CYCLES=2.
module tb_led_blink_emitter;
   import blink_pkg::*;

   localparam int ON_C  = 3;
   localparam int OFF_C = 2;
   localparam int P     = ON_C + OFF_C;

   logic       clk;
   logic       reset;
   logic       start;
   logic [3:0] count;
   logic       led;
   logic       busy;
   logic       done;
   logic [3:0] remaining;
   state_t     fsm_state;

   int total = 0;
   int bad   = 0;

   led_blink_emitter #(
      .ON_CYCLES  (ON_C),
      .OFF_CYCLES (OFF_C)
   ) dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .count     (count),
      .led       (led),
      .busy      (busy),
      .done      (done),
      .remaining (remaining),
      .fsm_state (fsm_state)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock; outputs are then sampled 1 time unit after the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_outputs(input string tag, input logic e_led, input logic e_busy,
                              input logic e_done, input logic [3:0] e_rem, input state_t e_st);
      chk({tag, " led"},   8'(led),       8'(e_led));
      chk({tag, " busy"},  8'(busy),      8'(e_busy));
      chk({tag, " done"},  8'(done),      8'(e_done));
      chk({tag, " rem"},   8'(remaining), 8'(e_rem));
      chk({tag, " state"}, 8'(fsm_state), 8'(e_st));
   endtask

   // Issue a request for n blinks and check every cycle T+1 .. T+n*P+3
   // against the timing formulas. If poke_k > 0, a start with count=9 is
   // presented at edge T+poke_k and must be ignored.
   task automatic run_seq(input int n, input int poke_k);
      int     idx;
      int     ph;
      int     rises;
      logic   prev;
      logic   e_led;
      logic   e_busy;
      logic   e_done;
      logic [3:0] e_rem;
      state_t e_st;
      rises = 0;
      prev  = 1'b0;
      start = 1'b1;
      count = n[3:0];
      for (int k = 1; k <= n * P + 3; k++) begin
         tick();
         start = 1'b0;
         count = 4'($urandom_range(0, 15));
         e_busy = (k >= 1) && (k <= n * P);
         e_done = (k == n * P + 1);
         if (e_busy) begin
            idx   = (k - 1) / P;
            ph    = (k - 1) % P;
            e_led = (ph < ON_C);
            e_rem = 4'(n - idx - ((ph >= ON_C) ? 1 : 0));
            e_st  = e_led ? ON : OFF;
         end else begin
            e_led = 1'b0;
            e_rem = 4'd0;
            e_st  = IDLE;
         end
         chk_outputs($sformatf("n=%0d k=%0d", n, k), e_led, e_busy, e_done, e_rem, e_st);
         if (led && !prev) rises++;
         prev = led;
         if (k == poke_k) begin
            start = 1'b1;
            count = 4'd9;
         end
      end
      chk($sformatf("n=%0d rising edges", n), 8'(rises), 8'(n));
   endtask

   initial begin
      reset = 1'b0;
      start = 1'b0;
      count = 4'd0;

      // Reset held for 3 cycles, then released with no request.
      for (int i = 0; i < 3; i++) begin
         tick();
         chk_outputs($sformatf("in reset %0d", i), 1'b0, 1'b0, 1'b0, 4'd0, IDLE);
      end
      reset = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_outputs($sformatf("idle %0d", i), 1'b0, 1'b0, 1'b0, 4'd0, IDLE);
      end

      // Three blinks.
      run_seq(3, 0);
      tick();

      // Zero-length request.
      run_seq(0, 0);

      // Two blinks with an ignored start at T+4.
      run_seq(2, 4);
      tick();

      // Five blinks, aborted by reset during cycle T+7.
      start = 1'b1;
      count = 4'd5;
      tick();
      start = 1'b0;
      for (int k = 2; k <= 7; k++) tick();
      chk_outputs("pre-abort T+7", 1'b1, 1'b1, 1'b0, 4'd4, ON);
      reset = 1'b0;
      #1;
      chk_outputs("abort async", 1'b0, 1'b0, 1'b0, 4'd0, IDLE);
      tick();
      tick();
      reset = 1'b1;
      for (int i = 0; i < 2 * P + 2; i++) begin
         tick();
         chk_outputs($sformatf("post-abort %0d", i), 1'b0, 1'b0, 1'b0, 4'd0, IDLE);
      end
      run_seq(1, 0);

      // Maximum count: 15 blinks, 75 busy cycles, no wrap.
      run_seq(15, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/led_blink_emitter.md
# led_blink_emitter

Output-side counterpart to the push-button debouncer: the debouncer turns a noisy human press into a clean count, and this block turns a clean count back into something a human can see. On a `start` request it latches a 4-bit count N and blinks one LED exactly N times with programmable on/off durations, then pulses `done`. It sits between the game/control logic and the board LED pins, and typically replays the debouncer's press count as visual feedback.

## Interface
Parameters:
- `ON_CYCLES`, default 25_000_000: LED-high duration per blink, in clk cycles; must be ≥ 1.
- `OFF_CYCLES`, default 25_000_000: LED-low duration after each blink, in clk cycles; must be ≥ 1.

Ports:
- `clk`  in  1  system clock; one clock domain.
- `reset`  in  1  asynchronous, active-low; asserted (0) forces all state and outputs to reset values immediately.
- `start`  in  1  request; sampled on the rising edge of `clk`; honoured only when `busy`=0.
- `count`  in  4  number of blinks, 0..15; sampled with `start`.
- `led`  out  1  registered LED drive; 1 = lit.
- `busy`  out  1  registered; high while a blink sequence is running.
- `done`  out  1  registered; one-cycle pulse when a request completes.
- `remaining`  out  4  registered; blinks not yet started, including the current one while `led`=1.

## Operation
- Reset values: `led`=0, `busy`=0, `done`=0, `remaining`=0; FSM in IDLE; timer = 0.
- FSM states: IDLE, ON, OFF.
- IDLE:
  - `start`=1 and `count`≠0: latch `count` into `remaining`, load timer with ON_CYCLES−1, go to ON.
  - `start`=1 and `count`=0: stay in IDLE and pulse `done` for one cycle.
- ON: `led`=1. When the timer reaches 0, decrement `remaining`, load timer with OFF_CYCLES−1, go to OFF.
- OFF: `led`=0. When the timer reaches 0:
  - `remaining`≠0: load ON_CYCLES−1 and go to ON.
  - `remaining`=0: go to IDLE and pulse `done`.
- `busy` is 1 exactly in ON and OFF.
- `start` while `busy`=1 is ignored. Changes to `count` while `busy`=1 are ignored.
- A trailing OFF period is always included, so back-to-back requests stay visually separated.
- `remaining` never wraps: it is decremented only in ON, where it is ≥ 1.
- Reset during a sequence aborts it. No `done` pulse is generated and no state survives.
- Timer width is `$clog2(max(ON_CYCLES,OFF_CYCLES))`, minimum 1 bit. Timer arithmetic is unsigned; decrement happens only when nonzero.

## Timing
- Let T be the edge at which an accepted `start` is sampled.
- N≥1:
  - From T+1: `busy`=1, `led`=1, `remaining`=N.
  - Blink k (k = 0..N−1): `led`=1 for cycles T+1+k·P .. T+k·P+ON_CYCLES, where P = ON_CYCLES+OFF_CYCLES; `led`=0 for the following OFF_CYCLES cycles.
  - `busy` is high for exactly N·P cycles.
  - At cycle T+N·P+1: `busy`=0, `done`=1 for that single cycle, `remaining`=0.
  - A new `start` is accepted at that same edge.
- N=0: `done`=1 at T+1 only; `busy` never rises; `led` stays 0.
- Latency from `start` to first LED edge: 1 cycle.

## Structure
- Shared package `blink_pkg`:
  - state enum {IDLE, ON, OFF};
  - default timing constants `BLINK_ON_DEFAULT` and `BLINK_OFF_DEFAULT` (0.5 s at 50 MHz).
- One sub-module, `tick_timer`: loadable down-counter with inputs `load`/`value` and a registered `zero` flag; instantiated once.
- Top level holds the FSM, the `remaining` register and the output registers.

## Test plan
All scenarios use ON_CYCLES=3, OFF_CYCLES=2, so P=5.
- Reset held low for 3 cycles, then released → `led`, `busy`, `done`, `remaining` all 0; no activity without `start`.
- `start`=1 with `count`=3 at edge T → `led`=1 during T+1..T+3, T+6..T+8, T+11..T+13, and 0 otherwise. `busy`=1 during T+1..T+15. `remaining` steps 3→2 (T+4), 1 (T+9), 0 (T+14). `done`=1 only at T+16.
- `start` with `count`=0 → `done`=1 at T+1 only; `busy` and `led` stay 0.
- `count`=2 accepted; `start` with `count`=9 pulsed at T+4 → ignored. Exactly 2 blinks occur and `done` is high at T+11.
- `count`=5 accepted; `reset` pulled low at T+7 → `led`=0, `busy`=0, `remaining`=0 within the same cycle. No `done` follows, and a fresh `start` is accepted after release.
- `count`=15 → exactly 15 `led` rising edges; `busy` high for 75 cycles; `remaining` ends at 0 with no wrap to 15.
